inst_fetch: RTL and testbench

//  Front-end stage directly upstream of the decode stage. Generates the PC, fetches
//  32-bit instructions from instruction memory over a one-outstanding req/rvalid

---
 rtl/inst_fetch.sv | 149 ++++++++++++++
 tb/tb_inst_fetch.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch front end: PC generation, single-outstanding imem handshake,
// local JAL resolution, branch/JALR redirects and NOP bubble insertion toward decode.
module inst_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        jalr_valid,
  input  logic [63:0] jalr_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] inst,
  output logic [63:0] PC_o,
  output logic        misalign
);

  typedef enum logic [1:0] {S_BOOT, S_WAIT, S_HOLD, S_DROP} state_t;

  localparam logic [63:0] ALIGN_MASK = ~64'h3;
  localparam logic [6:0]  OP_JAL     = 7'b1101111;

  state_t      r_state, w_state_n;
  logic [63:0] r_fetch_pc, w_fetch_n;   // address of the outstanding (or next) request
  logic        r_req, w_req_n;
  logic [63:0] r_addr, w_addr_n;
  logic [31:0] r_inst, w_inst_n;
  logic [63:0] r_pc, w_pc_n;
  logic [31:0] r_hold_inst, w_hold_inst_n;
  logic [63:0] r_hold_pc, w_hold_pc_n;
  logic        r_misalign, w_misalign_n;

  logic        w_redir;
  logic [63:0] w_tgt_raw, w_tgt;
  logic [63:0] w_jal_imm, w_next_pc;

  assign w_redir   = branch_taken | jalr_valid;
  assign w_tgt_raw = branch_taken ? branch_target : jalr_target;
  assign w_tgt     = w_tgt_raw & ALIGN_MASK;

  assign w_jal_imm = {{43{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                      imem_rdata[20], imem_rdata[30:21], 1'b0};
  assign w_next_pc = ((imem_rdata[6:0] == OP_JAL) ? (r_fetch_pc + w_jal_imm)
                                                  : (r_fetch_pc + 64'd4)) & ALIGN_MASK;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state     <= S_BOOT;
      r_fetch_pc  <= RESET_PC & ALIGN_MASK;
      r_req       <= 1'b0;
      r_addr      <= RESET_PC & ALIGN_MASK;
      r_inst      <= NOP_INST;
      r_pc        <= RESET_PC;
      r_hold_inst <= NOP_INST;
      r_hold_pc   <= RESET_PC;
      r_misalign  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_fetch_pc  <= w_fetch_n;
      r_req       <= w_req_n;
      r_addr      <= w_addr_n;
      r_inst      <= w_inst_n;
      r_pc        <= w_pc_n;
      r_hold_inst <= w_hold_inst_n;
      r_hold_pc   <= w_hold_pc_n;
      r_misalign  <= w_misalign_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_fetch_n     = r_fetch_pc;
    w_req_n       = 1'b0;
    w_addr_n      = r_addr;
    w_inst_n      = r_inst;
    w_pc_n        = r_pc;
    w_hold_inst_n = r_hold_inst;
    w_hold_pc_n   = r_hold_pc;
    w_misalign_n  = r_misalign | (w_redir && (w_tgt_raw[1:0] != 2'b00));

    if (w_redir) begin
      // Redirect beats stall; a response landing this same cycle is discarded.
      w_inst_n  = NOP_INST;
      w_fetch_n = w_tgt;
      if ((r_state == S_WAIT || r_state == S_DROP) && !imem_rvalid) begin
        w_state_n = S_DROP;
      end else begin
        w_req_n   = 1'b1;
        w_addr_n  = w_tgt;
        w_state_n = S_WAIT;
      end
    end else begin
      case (r_state)
        S_BOOT: begin
          w_req_n   = 1'b1;
          w_addr_n  = r_fetch_pc;
          w_state_n = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            w_fetch_n = w_next_pc;
            if (!stall) begin
              w_inst_n = imem_rdata;
              w_pc_n   = r_fetch_pc;
              w_req_n  = 1'b1;
              w_addr_n = w_next_pc;
            end else begin
              w_hold_inst_n = imem_rdata;
              w_hold_pc_n   = r_fetch_pc;
              w_state_n     = S_HOLD;
            end
          end else if (!stall) begin
            w_inst_n = NOP_INST;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            w_inst_n  = r_hold_inst;
            w_pc_n    = r_hold_pc;
            w_req_n   = 1'b1;
            w_addr_n  = r_fetch_pc;
            w_state_n = S_WAIT;
          end
        end
        S_DROP: begin
          w_inst_n = NOP_INST;
          if (imem_rvalid) begin
            w_req_n   = 1'b1;
            w_addr_n  = r_fetch_pc;
            w_state_n = S_WAIT;
          end
        end
        default: w_state_n = S_BOOT;
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign inst      = r_inst;
  assign PC_o      = r_pc;
  assign misalign  = r_misalign;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: the bench plays instruction memory cycle by cycle.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  logic        CLK = 1'b0;
  logic        reset, stall, branch_taken, jalr_valid, imem_rvalid;
  logic [63:0] branch_target, jalr_target;
  logic [31:0] imem_rdata;
  logic        imem_req, misalign;
  logic [63:0] imem_addr, PC_o;
  logic [31:0] inst;

  int total = 0;
  int bad   = 0;

  inst_fetch dut (
    .CLK(CLK), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jalr_valid(jalr_valid), .jalr_target(jalr_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .inst(inst), .PC_o(PC_o), .misalign(misalign)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_inst"}, {32'h0, inst}, {32'h0, NOP});
    chk({tag, "_pc"},   PC_o, 64'h0);
    chk({tag, "_req"},  {63'h0, imem_req}, 64'h0);
    chk({tag, "_addr"}, imem_addr, 64'h0);
    chk({tag, "_mis"},  {63'h0, misalign}, 64'h0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jalr_valid = 1'b0;
    branch_target = '0; jalr_target = '0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (2) tick();
    chk_reset("rst");

    // 1: boot and two sequential fetches
    reset = 1'b0; tick();
    chk("t1_req0", {63'h0, imem_req}, 64'h1);
    chk("t1_addr0", imem_addr, 64'h0);
    chk("t1_nop0", {32'h0, inst}, {32'h0, NOP});
    tick();
    chk("t1_noreq", {63'h0, imem_req}, 64'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h00000093; tick();
    chk("t1_inst0", {32'h0, inst}, 64'h93);
    chk("t1_pc0", PC_o, 64'h0);
    chk("t1_addr4", imem_addr, 64'h4);
    imem_rvalid = 1'b0; tick();
    chk("t1_bubble", {32'h0, inst}, {32'h0, NOP});
    imem_rvalid = 1'b1; imem_rdata = 32'h00100113; tick();
    chk("t1_inst1", {32'h0, inst}, 64'h00100113);
    chk("t1_pc4", PC_o, 64'h4);
    chk("t1_addr8", imem_addr, 64'h8);

    // 2: stall across a response
    imem_rvalid = 1'b0; stall = 1'b1; tick();
    chk("t2_frz0", {32'h0, inst}, 64'h00100113);
    imem_rvalid = 1'b1; imem_rdata = 32'h00200193; tick();
    chk("t2_frz1", {32'h0, inst}, 64'h00100113);
    chk("t2_frzpc", PC_o, 64'h4);
    chk("t2_noreq1", {63'h0, imem_req}, 64'h0);
    imem_rvalid = 1'b0; tick();
    chk("t2_frz2", {32'h0, inst}, 64'h00100113);
    chk("t2_noreq2", {63'h0, imem_req}, 64'h0);
    stall = 1'b0; tick();
    chk("t2_held", {32'h0, inst}, 64'h00200193);
    chk("t2_heldpc", PC_o, 64'h8);
    chk("t2_req", {63'h0, imem_req}, 64'h1);
    chk("t2_addr", imem_addr, 64'hC);
    tick();
    chk("t2_once", {32'h0, inst}, {32'h0, NOP});

    // 3: JAL +16 at 0x10
    imem_rvalid = 1'b1; imem_rdata = 32'h00300213; tick();
    chk("t3_addr10", imem_addr, 64'h10);
    imem_rvalid = 1'b0; tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0100006F; tick();
    chk("t3_jal", {32'h0, inst}, 64'h0100006F);
    chk("t3_pc", PC_o, 64'h10);
    chk("t3_req", {63'h0, imem_req}, 64'h1);
    chk("t3_addr", imem_addr, 64'h20);

    // 4: branch while a request is outstanding
    imem_rvalid = 1'b0; tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h00400293; tick();
    chk("t4_addr24", imem_addr, 64'h24);
    imem_rvalid = 1'b0; branch_taken = 1'b1; branch_target = 64'h80; tick();
    chk("t4_nop", {32'h0, inst}, {32'h0, NOP});
    chk("t4_pc", PC_o, 64'h20);
    chk("t4_noreq", {63'h0, imem_req}, 64'h0);
    branch_taken = 1'b0; imem_rvalid = 1'b1; imem_rdata = BAD; tick();
    chk("t4_drop", {32'h0, inst}, {32'h0, NOP});
    chk("t4_req", {63'h0, imem_req}, 64'h1);
    chk("t4_addr", imem_addr, 64'h80);
    imem_rvalid = 1'b0; tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h00500313; tick();
    chk("t4_inst", {32'h0, inst}, 64'h00500313);
    chk("t4_pc80", PC_o, 64'h80);

    // 5: branch beats jalr, same cycle as a response (response discarded)
    imem_rdata = BAD; branch_taken = 1'b1; branch_target = 64'h40;
    jalr_valid = 1'b1; jalr_target = 64'h60; tick();
    chk("t5_req", {63'h0, imem_req}, 64'h1);
    chk("t5_addr", imem_addr, 64'h40);
    chk("t5_nop", {32'h0, inst}, {32'h0, NOP});
    branch_taken = 1'b0; jalr_valid = 1'b0; imem_rvalid = 1'b0; tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h00600393; tick();
    chk("t5_pc", PC_o, 64'h40);
    chk("t5_next", imem_addr, 64'h44);
    chk("t5_mis", {63'h0, misalign}, 64'h0);

    // 6: misaligned jalr, then reset mid-wait
    imem_rvalid = 1'b0; jalr_valid = 1'b1; jalr_target = 64'h102; tick();
    chk("t6_mis", {63'h0, misalign}, 64'h1);
    chk("t6_noreq", {63'h0, imem_req}, 64'h0);
    jalr_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = BAD; tick();
    chk("t6_addr", imem_addr, 64'h100);
    chk("t6_req", {63'h0, imem_req}, 64'h1);
    chk("t6_sticky", {63'h0, misalign}, 64'h1);
    imem_rvalid = 1'b0; reset = 1'b1; #1;
    chk_reset("t6_rst");
    tick();
    reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = BAD; tick();
    chk("t6_boot_req", {63'h0, imem_req}, 64'h1);
    chk("t6_boot_addr", imem_addr, 64'h0);
    imem_rvalid = 1'b0; tick();
    chk("t6_ignored", {32'h0, inst}, {32'h0, NOP});
    chk("t6_pc", PC_o, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
